// File: rtl/board_memory_engine.sv
// board_memory_engine
// Keeps the table/hand card map, the table snapshot used to undo a turn,
// the deck availability vector and the deck / opponent card counts.
// Commands arrive one at a time over cmd_valid/cmd_ready.
// Build option: define BME_PARALLEL_SHIFT_EN to make TABLE_SHIFT finish in
// its accept cycle; without it the shift walks one cell per cycle.
module board_memory_engine #(
    parameter int COLS   = 18,
    parameter int ROWS   = 8,
    parameter int CARD_W = 6,
    parameter int EMPTY  = 54,
    parameter int UNIQUE = 54,
    parameter int DUP    = 52,
    parameter int NCARDS = 106,
    parameter int X_W    = 5,
    parameter int Y_W    = 3,
    parameter int LEN_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_remote,
    input  logic [3:0]                    cmd_type,
    input  logic [X_W-1:0]                cmd_x,
    input  logic [Y_W-1:0]                cmd_y,
    input  logic [CARD_W-1:0]             cmd_card,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic                          cmd_dir,
    output logic [ROWS*COLS*CARD_W-1:0]   map,
    output logic [NCARDS-1:0]             available_card,
    output logic [6:0]                    deck_cnt,
    output logic [6:0]                    oppo_cnt,
    output logic                          cmd_err
);

    localparam int CELLS = ROWS * COLS;
    localparam int MAP_W = CELLS * CARD_W;
    localparam int PW    = $clog2(CELLS);
    localparam int MI_W  = $clog2(MAP_W);
    localparam int AI_W  = $clog2(NCARDS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [3:0] CMD_TABLE_TAKE  = 4'd0;
    localparam logic [3:0] CMD_TABLE_DOWN  = 4'd1;
    localparam logic [3:0] CMD_TABLE_SHIFT = 4'd2;
    localparam logic [3:0] CMD_HAND_TAKE   = 4'd3;
    localparam logic [3:0] CMD_HAND_DOWN   = 4'd4;
    localparam logic [3:0] CMD_DECK_DRAW   = 4'd5;
    localparam logic [3:0] CMD_STATE_TURN  = 4'd6;
    localparam logic [3:0] CMD_STATE_RST   = 4'd7;

    localparam logic [CARD_W-1:0] EMPTY_CODE = CARD_W'(EMPTY);

    // Bit offset of cell p inside the flattened map.
    function automatic logic [MI_W-1:0] cell_ofs(input int p);
        cell_ofs = MI_W'(p * CARD_W);
    endfunction

    // A map with every cell holding the empty code.
    function automatic logic [MAP_W-1:0] empty_map();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int p = 0; p < CELLS; p++) begin
            m[cell_ofs(p) +: CARD_W] = EMPTY_CODE;
        end
        return m;
    endfunction

    logic [0:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [MAP_W-1:0]  map_q, map_d;
    logic [MAP_W-1:0]  snap_q, snap_d;
    logic [NCARDS-1:0] avail_q, avail_d;
    logic [6:0]        deck_q, deck_d;
    logic [6:0]        oppo_q, oppo_d;
    logic [6:0]        pend_q, pend_d;
    logic              src_vld_q, src_vld_d;
    logic [PW-1:0]     src_pos_q, src_pos_d;
    logic [X_W-1:0]    sh_x_q, sh_x_d;
    logic [Y_W-1:0]    sh_y_q, sh_y_d;
    logic [LEN_W-1:0]  sh_len_q, sh_len_d;
    logic [LEN_W-1:0]  sh_step_q, sh_step_d;
    logic              sh_dir_q, sh_dir_d;

    int   x_i, y_i, len_i, c_i, p_i, dst_i, row_i, src_c, dst_c;
    logic pos_ok;

    // Next-state logic: shift stepping while busy, command decode while idle.
    always_comb begin
        state_d   = state_q;
        map_d     = map_q;
        snap_d    = snap_q;
        avail_d   = avail_q;
        deck_d    = deck_q;
        oppo_d    = oppo_q;
        pend_d    = pend_q;
        src_vld_d = src_vld_q;
        src_pos_d = src_pos_q;
        sh_x_d    = sh_x_q;
        sh_y_d    = sh_y_q;
        sh_len_d  = sh_len_q;
        sh_step_d = sh_step_q;
        sh_dir_d  = sh_dir_q;
        err_d     = 1'b0;
        x_i       = int'(cmd_x);
        y_i       = int'(cmd_y);
        len_i     = int'(cmd_len);
        c_i       = int'(cmd_card);
        p_i       = y_i * COLS + x_i;
        pos_ok    = (x_i < COLS) && (y_i < ROWS);
        row_i     = int'(sh_y_q) * COLS;
        src_c     = 0;
        dst_c     = 0;
        dst_i     = 0;

        if (state_q == ST_SHIFT) begin
            // Right shift walks from the far end inward, left from x outward,
            // so every step reads a cell no earlier step has touched.
            if (sh_dir_q) begin
                src_c = int'(sh_x_q) + int'(sh_len_q) - 1 - int'(sh_step_q);
                dst_c = src_c + 1;
            end else begin
                src_c = int'(sh_x_q) + int'(sh_step_q);
                dst_c = src_c - 1;
            end
            if (dst_c < COLS) begin
                if (src_c < COLS) begin
                    map_d[cell_ofs(row_i + dst_c) +: CARD_W] = map_q[cell_ofs(row_i + src_c) +: CARD_W];
                end else begin
                    map_d[cell_ofs(row_i + dst_c) +: CARD_W] = EMPTY_CODE;
                end
            end else begin
                map_d = map_d;
            end
            if (src_c < COLS) begin
                map_d[cell_ofs(row_i + src_c) +: CARD_W] = EMPTY_CODE;
            end else begin
                map_d = map_d;
            end
            if (int'(sh_step_q) == int'(sh_len_q) - 1) begin
                state_d = ST_IDLE;
            end else begin
                sh_step_d = sh_step_q + LEN_W'(1);
            end
        end else if (cmd_valid && ready_q) begin
            case (cmd_type)
                CMD_TABLE_TAKE: begin
                    if (!pos_ok) begin
                        err_d = 1'b1;
                    end else begin
                        src_vld_d = 1'b1;
                        src_pos_d = PW'(p_i);
                    end
                end
                CMD_TABLE_DOWN, CMD_HAND_DOWN: begin
                    if (!pos_ok) begin
                        err_d = 1'b1;
                    end else begin
                        // Clear the source first so a pick-up and put-down on
                        // the same cell leaves the new card in place.
                        if (src_vld_q) begin
                            map_d[cell_ofs(int'(src_pos_q)) +: CARD_W] = EMPTY_CODE;
                        end else begin
                            map_d = map_d;
                        end
                        if (cmd_type == CMD_HAND_DOWN && cmd_remote) begin
                            pend_d = (pend_q == 7'd127) ? pend_q : pend_q + 7'd1;
                        end else begin
                            map_d[cell_ofs(p_i) +: CARD_W] = cmd_card;
                        end
                        src_vld_d = 1'b0;
                    end
                end
                CMD_TABLE_SHIFT: begin
                    if (!pos_ok || len_i == 0 || (cmd_dir && (x_i + len_i > COLS - 1)) || (!cmd_dir && x_i == 0)) begin
                        err_d = 1'b1;
                    end else begin
                        dst_i = cmd_dir ? (p_i + len_i) : (p_i - 1);
                        if (map_q[cell_ofs(dst_i) +: CARD_W] != EMPTY_CODE) begin
                            err_d = 1'b1;
                        end else begin
`ifdef BME_PARALLEL_SHIFT_EN
                            for (int c = 0; c < COLS; c++) begin
                                if (cmd_dir) begin
                                    if (c == x_i) begin
                                        map_d[cell_ofs(y_i * COLS + c) +: CARD_W] = EMPTY_CODE;
                                    end else if (c > x_i && c <= x_i + len_i) begin
                                        map_d[cell_ofs(y_i * COLS + c) +: CARD_W] = map_q[cell_ofs(y_i * COLS + c - 1) +: CARD_W];
                                    end else begin
                                        map_d = map_d;
                                    end
                                end else begin
                                    if (c >= x_i - 1 && c <= x_i + len_i - 2) begin
                                        map_d[cell_ofs(y_i * COLS + c) +: CARD_W] =
                                            (c + 1 < COLS) ? map_q[cell_ofs(y_i * COLS + c + 1) +: CARD_W] : EMPTY_CODE;
                                    end else if (c == x_i + len_i - 1) begin
                                        map_d[cell_ofs(y_i * COLS + c) +: CARD_W] = EMPTY_CODE;
                                    end else begin
                                        map_d = map_d;
                                    end
                                end
                            end
`else
                            state_d   = ST_SHIFT;
                            sh_x_d    = cmd_x;
                            sh_y_d    = cmd_y;
                            sh_len_d  = cmd_len;
                            sh_dir_d  = cmd_dir;
                            sh_step_d = '0;
`endif
                        end
                    end
                end
                CMD_HAND_TAKE: begin
                    if (!pos_ok) begin
                        err_d = 1'b1;
                    end else if (cmd_remote) begin
                        src_vld_d = 1'b0;
                        pend_d    = (pend_q == 7'd0) ? pend_q : pend_q - 7'd1;
                    end else begin
                        src_vld_d = 1'b1;
                        src_pos_d = PW'(p_i);
                    end
                end
                CMD_DECK_DRAW: begin
                    // First copy lives at index c, the duplicate at c+UNIQUE.
                    if (c_i >= UNIQUE) begin
                        err_d = 1'b1;
                    end else if (avail_q[AI_W'(c_i)]) begin
                        avail_d[AI_W'(c_i)] = 1'b0;
                        deck_d    = (deck_q == 7'd0) ? deck_q : deck_q - 7'd1;
                        src_vld_d = 1'b0;
                    end else if (c_i < DUP && avail_q[AI_W'(c_i + UNIQUE)]) begin
                        avail_d[AI_W'(c_i + UNIQUE)] = 1'b0;
                        deck_d    = (deck_q == 7'd0) ? deck_q : deck_q - 7'd1;
                        src_vld_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_STATE_TURN: begin
                    snap_d    = map_q;
                    oppo_d    = pend_q;
                    src_vld_d = 1'b0;
                end
                CMD_STATE_RST: begin
                    map_d     = snap_q;
                    pend_d    = oppo_q;
                    src_vld_d = 1'b0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // State registers; reset also abandons any shift in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            map_q     <= empty_map();
            snap_q    <= empty_map();
            avail_q   <= '1;
            deck_q    <= 7'(NCARDS);
            oppo_q    <= 7'd0;
            pend_q    <= 7'd0;
            src_vld_q <= 1'b0;
            src_pos_q <= '0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_len_q  <= '0;
            sh_step_q <= '0;
            sh_dir_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            map_q     <= map_d;
            snap_q    <= snap_d;
            avail_q   <= avail_d;
            deck_q    <= deck_d;
            oppo_q    <= oppo_d;
            pend_q    <= pend_d;
            src_vld_q <= src_vld_d;
            src_pos_q <= src_pos_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            sh_len_q  <= sh_len_d;
            sh_step_q <= sh_step_d;
            sh_dir_q  <= sh_dir_d;
        end
    end

    assign cmd_ready      = ready_q;
    assign cmd_err        = err_q;
    assign map            = map_q;
    assign available_card = avail_q;
    assign deck_cnt       = deck_q;
    assign oppo_cnt       = oppo_q;

endmodule

// File: tb/tb_board_memory_engine.sv
// Testbench for board_memory_engine: directed plan steps followed by random
// commands, each checked against a card-table model kept as 2-D arrays.
module tb_board_memory_engine;

    localparam int COLS   = 18;
    localparam int ROWS   = 8;
    localparam int CARD_W = 6;
    localparam int EMPTY  = 54;
    localparam int UNIQUE = 54;
    localparam int DUP    = 52;
    localparam int NCARDS = 106;
    localparam int MAP_W  = ROWS * COLS * CARD_W;
    localparam int MI_W   = 10;
`ifdef BME_PARALLEL_SHIFT_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_remote;
    logic [3:0]        cmd_type;
    logic [4:0]        cmd_x;
    logic [2:0]        cmd_y;
    logic [5:0]        cmd_card;
    logic [2:0]        cmd_len;
    logic              cmd_dir;
    logic [MAP_W-1:0]  map;
    logic [NCARDS-1:0] available_card;
    logic [6:0]        deck_cnt;
    logic [6:0]        oppo_cnt;
    logic              cmd_err;

    board_memory_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_remote(cmd_remote), .cmd_type(cmd_type), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_card(cmd_card), .cmd_len(cmd_len), .cmd_dir(cmd_dir), .map(map),
        .available_card(available_card), .deck_cnt(deck_cnt), .oppo_cnt(oppo_cnt),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model of the board.
    int m_map  [ROWS][COLS];
    int m_snap [ROWS][COLS];
    bit m_avail[NCARDS];
    int m_deck, m_oppo, m_pend, m_sx, m_sy;
    bit m_src;

    function automatic logic [CARD_W-1:0] get_cell(input int p);
        logic [MI_W-1:0] o;
        o = MI_W'(p * CARD_W);
        return map[o +: CARD_W];
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_map(input string tag);
        logic [MAP_W-1:0] e;
        logic [MI_W-1:0]  o;
        int bad;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                o = MI_W'((y * COLS + x) * CARD_W);
                e[o +: CARD_W] = CARD_W'(m_map[y][x]);
            end
        end
        n_assert++;
        assert (map === e) else begin
            n_fail++;
            bad = 0;
            for (int p = ROWS * COLS - 1; p >= 0; p--) begin
                o = MI_W'(p * CARD_W);
                if (map[o +: CARD_W] !== e[o +: CARD_W]) bad = p;
            end
            o = MI_W'(bad * CARD_W);
            $error("FAIL %s map: cell %0d observed %0d expected %0d", tag, bad, map[o +: CARD_W], e[o +: CARD_W]);
        end
    endtask

    task automatic check_state(input string tag);
        logic [NCARDS-1:0] ea;
        for (int i = 0; i < NCARDS; i++) ea[i] = m_avail[i];
        check_map(tag);
        n_assert++;
        assert (available_card === ea) else begin
            n_fail++;
            $error("FAIL %s avail: observed %h expected %h", tag, available_card, ea);
        end
        check_val({tag, " deck"}, 64'(deck_cnt), 64'(m_deck));
        check_val({tag, " oppo"}, 64'(oppo_cnt), 64'(m_oppo));
    endtask

    task automatic model_reset();
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                m_map[y][x]  = EMPTY;
                m_snap[y][x] = EMPTY;
            end
        end
        for (int i = 0; i < NCARDS; i++) m_avail[i] = 1'b1;
        m_deck = NCARDS; m_oppo = 0; m_pend = 0; m_src = 1'b0;
    endtask

    // Apply one command to the model; reports expected error and whether a shift ran.
    task automatic model_cmd(input int t, input int r, input int x, input int y, input int c,
                             input int len, input int dir, output bit err, output bit shifted);
        int dst;
        err = 1'b0; shifted = 1'b0;
        if (t <= 4 && (x >= COLS || y >= ROWS)) begin
            err = 1'b1;
            return;
        end
        case (t)
            0: begin m_src = 1'b1; m_sx = x; m_sy = y; end
            1, 4: begin
                if (m_src) m_map[m_sy][m_sx] = EMPTY;
                if (t == 4 && r != 0) begin
                    if (m_pend < 127) m_pend++;
                end else begin
                    m_map[y][x] = c;
                end
                m_src = 1'b0;
            end
            2: begin
                dst = dir ? x + len : x - 1;
                if (len == 0 || (dir && x + len > COLS - 1) || (!dir && x == 0) || m_map[y][dst] != EMPTY) begin
                    err = 1'b1;
                end else begin
                    shifted = 1'b1;
                    if (dir) begin
                        for (int k = len - 1; k >= 0; k--) m_map[y][x + k + 1] = m_map[y][x + k];
                        m_map[y][x] = EMPTY;
                    end else begin
                        for (int k = 0; k < len; k++)
                            if (x + k - 1 < COLS) m_map[y][x + k - 1] = (x + k < COLS) ? m_map[y][x + k] : EMPTY;
                        if (x + len - 1 < COLS) m_map[y][x + len - 1] = EMPTY;
                    end
                end
            end
            3: begin
                if (r != 0) begin
                    m_src = 1'b0;
                    if (m_pend > 0) m_pend--;
                end else begin
                    m_src = 1'b1; m_sx = x; m_sy = y;
                end
            end
            5: begin
                if (c >= UNIQUE) err = 1'b1;
                else if (m_avail[c]) m_avail[c] = 1'b0;
                else if (c < DUP && m_avail[c + UNIQUE]) m_avail[c + UNIQUE] = 1'b0;
                else err = 1'b1;
                if (!err) begin
                    if (m_deck > 0) m_deck--;
                    m_src = 1'b0;
                end
            end
            6: begin m_snap = m_map; m_oppo = m_pend; m_src = 1'b0; end
            7: begin m_map = m_snap; m_pend = m_oppo; m_src = 1'b0; end
            default: ;
        endcase
    endtask

    // Issue one command (entered and left just after a falling edge) and check it.
    task automatic do_cmd(input string tag, input int t, input int r, input int x, input int y,
                          input int c, input int len, input int dir);
        bit exp_err, shifted;
        int busy;
        check_val({tag, " ready"}, 64'(cmd_ready), 64'd1);
        cmd_type = 4'(t); cmd_remote = 1'(r); cmd_x = 5'(x); cmd_y = 3'(y);
        cmd_card = 6'(c); cmd_len = 3'(len); cmd_dir = 1'(dir);
        cmd_valid = 1'b1;
        model_cmd(t, r, x, y, c, len, dir, exp_err, shifted);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val({tag, " err"}, 64'(cmd_err), 64'(exp_err));
        busy = 0;
        while (cmd_ready !== 1'b1 && busy < 20) begin
            @(negedge clk);
            busy++;
        end
        check_val({tag, " busy"}, 64'(busy), (shifted && !PAR) ? 64'(len) : 64'd0);
        check_state(tag);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_remote = 1'b0; cmd_type = 4'd0;
        cmd_x = 5'd0; cmd_y = 3'd0; cmd_card = 6'd0; cmd_len = 3'd0; cmd_dir = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_state("reset");
        check_val("reset ready", 64'(cmd_ready), 64'd1);
        check_val("reset err", 64'(cmd_err), 64'd0);
        check_val("reset deck", 64'(deck_cnt), 64'd106);

        // Deck draws of card 5: first copy, duplicate, then exhausted
        do_cmd("draw5a", 5, 0, 0, 0, 5, 0, 0);
        check_val("draw5a bit5", 64'(available_card[5]), 64'd0);
        do_cmd("draw5b", 5, 0, 0, 0, 5, 0, 0);
        check_val("draw5b bit59", 64'(available_card[59]), 64'd0);
        check_val("draw5b deck", 64'(deck_cnt), 64'd104);
        do_cmd("draw5c", 5, 0, 0, 0, 5, 0, 0);
        check_val("draw5c deck", 64'(deck_cnt), 64'd104);

        // Take from (2,0) and put down at (4,1)
        do_cmd("place7", 1, 0, 2, 0, 7, 0, 0);
        do_cmd("take20", 0, 0, 2, 0, 0, 0, 0);
        do_cmd("down41", 1, 0, 4, 1, 7, 0, 0);
        check_val("down41 cell22", 64'(get_cell(22)), 64'd7);
        check_val("down41 cell2", 64'(get_cell(2)), 64'd54);

        // Right shift of three cells
        do_cmd("put3", 1, 0, 3, 0, 10, 0, 0);
        do_cmd("put4", 1, 0, 4, 0, 11, 0, 0);
        do_cmd("put5", 1, 0, 5, 0, 12, 0, 0);
        do_cmd("shr3", 2, 0, 3, 0, 0, 3, 1);
        check_val("shr3 cell3", 64'(get_cell(3)), 64'd54);
        check_val("shr3 cell4", 64'(get_cell(4)), 64'd10);
        check_val("shr3 cell6", 64'(get_cell(6)), 64'd12);

        // Snapshot restore and commit of opponent count
        do_cmd("turn1", 6, 0, 0, 0, 0, 0, 0);
        do_cmd("take41", 0, 0, 4, 1, 0, 0, 0);
        do_cmd("rdown1", 4, 1, 0, 0, 0, 0, 0);
        check_val("rdown1 cell22", 64'(get_cell(22)), 64'd54);
        do_cmd("rdown2", 4, 1, 0, 0, 0, 0, 0);
        do_cmd("rsttab", 7, 0, 0, 0, 0, 0, 0);
        check_val("rsttab cell22", 64'(get_cell(22)), 64'd7);
        check_val("rsttab oppo", 64'(oppo_cnt), 64'd0);
        do_cmd("take41b", 0, 0, 4, 1, 0, 0, 0);
        do_cmd("rdown3", 4, 1, 0, 0, 0, 0, 0);
        do_cmd("rdown4", 4, 1, 0, 0, 0, 0, 0);
        do_cmd("turn2", 6, 0, 0, 0, 0, 0, 0);
        check_val("turn2 oppo", 64'(oppo_cnt), 64'd2);

        // Rejections and shift range boundaries
        do_cmd("shl_x0", 2, 0, 0, 0, 0, 1, 0);
        do_cmd("take_x20", 0, 0, 20, 0, 0, 0, 0);
        do_cmd("down_x20", 1, 0, 20, 2, 9, 0, 0);
        do_cmd("shr_len0", 2, 0, 4, 0, 0, 0, 1);
        do_cmd("put14", 1, 0, 14, 3, 20, 0, 0);
        do_cmd("shr_far", 2, 0, 15, 3, 0, 3, 1);
        do_cmd("shr_edge", 2, 0, 14, 3, 0, 3, 1);
        do_cmd("shl_edge", 2, 0, 16, 3, 0, 2, 0);

        // Random commands
        for (int i = 0; i < 300; i++) begin
            int t, r, x, y, c, l, d;
            t = $urandom_range(9, 0);
            r = $urandom_range(1, 0);
            x = $urandom_range(19, 0);
            y = $urandom_range(ROWS - 1, 0);
            c = $urandom_range(63, 0);
            l = $urandom_range(7, 0);
            d = $urandom_range(1, 0);
            do_cmd("rand", t, r, x, y, c, l, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
